// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: FSM encodings, timeout
// default and the load-use detection helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    REDIR_PEND = 2'd2,
    HALTED     = 2'd3
  } pipe_state_t;

  localparam int          MEM_TIMEOUT_DEFAULT = 255;
  localparam logic [15:0] STALL_COUNT_MAX     = 16'hFFFF;

  function automatic logic loadUseHazard(
    input logic       memRead,
    input logic       writeEn,
    input logic [2:0] writeRegSel,
    input logic       rsUsed,
    input logic [2:0] regSelRs,
    input logic       rtUsed,
    input logic [2:0] regSelRt
  );
    return memRead & writeEn &
           ((rsUsed & (regSelRs == writeRegSel)) |
            (rtUsed & (regSelRt == writeRegSel)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter16.sv
// 16-bit up counter that sticks at its maximum value; synchronous active-low clear.
module sat_counter16
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != STALL_COUNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait
// stalls with timeout, and halt handling for a 4-stage in-order pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  regSelRs_D,
  input  logic [2:0]  regSelRt_D,
  input  logic        rsUsed_D,
  input  logic        rtUsed_D,
  input  logic        memRead_X,
  input  logic        writeEn_X,
  input  logic [2:0]  writeRegSel_X,
  input  logic        redirect_X,
  input  logic        memReq_M,
  input  logic        memDone_M,
  input  logic        halt_M,
  output logic        stall_FD,
  output logic        stall_DX,
  output logic        stall_XM,
  output logic        flush_FD,
  output logic        flush_DX,
  output logic        pcHold,
  output logic [1:0]  state,
  output logic        memFault,
  output logic [15:0] stallCount
);

  localparam int                CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  pipe_state_t      stateQ, stateD;
  logic             pendQ, pendD;
  logic [CNT_W-1:0] waitCntQ, waitCntD;
  logic             faultQ, faultD;
  logic             loadUse;

  assign loadUse = loadUseHazard(memRead_X, writeEn_X, writeRegSel_X,
                                 rsUsed_D, regSelRs_D, rtUsed_D, regSelRt_D);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= RUN;
      pendQ    <= 1'b0;
      waitCntQ <= '0;
      faultQ   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pendQ    <= pendD;
      waitCntQ <= waitCntD;
      faultQ   <= faultD;
    end
  end

  // Memory handshake: memReq_M starts an access, memDone_M marks its completion;
  // a request accepted together with its done costs nothing, otherwise the
  // whole pipe waits in MEM_WAIT until done (or timeout).
  always_comb begin
    stateD   = stateQ;
    pendD    = 1'b0;
    waitCntD = '0;
    faultD   = faultQ;
    unique case (stateQ)
      RUN: begin
        if (halt_M)                     stateD = HALTED;
        else if (memReq_M && !memDone_M) stateD = MEM_WAIT;
      end
      MEM_WAIT: begin
        // A redirect seen while waiting is replayed as a flush once memory completes.
        pendD = pendQ | redirect_X;
        if (halt_M) begin
          stateD = HALTED;
        end else if (memDone_M) begin
          stateD = pendD ? REDIR_PEND : RUN;
        end else if (waitCntQ == WAIT_LAST) begin
          faultD = 1'b1;
          stateD = HALTED;
        end else begin
          waitCntD = waitCntQ + CNT_W'(1);
        end
      end
      REDIR_PEND: begin
        stateD = halt_M ? HALTED : RUN;
      end
      HALTED: begin
        stateD = HALTED;
      end
      default: begin
        stateD = RUN;
      end
    endcase
  end

  always_comb begin
    stall_FD = 1'b0;
    stall_DX = 1'b0;
    stall_XM = 1'b0;
    flush_FD = 1'b0;
    flush_DX = 1'b0;
    pcHold   = 1'b0;
    if (!rst) begin
      // Reset pushes NOPs into the pipeline registers.
      flush_FD = 1'b1;
      flush_DX = 1'b1;
    end else begin
      unique case (stateQ)
        RUN: begin
          if (redirect_X) begin
            flush_FD = 1'b1;
            flush_DX = 1'b1;
          end else if (loadUse) begin
            pcHold   = 1'b1;
            stall_FD = 1'b1;
            flush_DX = 1'b1;
          end
        end
        REDIR_PEND: begin
          flush_FD = 1'b1;
          flush_DX = 1'b1;
        end
        MEM_WAIT, HALTED: begin
          pcHold   = 1'b1;
          stall_FD = 1'b1;
          stall_DX = 1'b1;
          stall_XM = 1'b1;
        end
        default: begin
          pcHold = 1'b0;
        end
      endcase
    end
  end

  assign state    = stateQ;
  assign memFault = faultQ;

  sat_counter16 u_stallCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_FD),
    .count (stallCount)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with MEM_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] O_IDLE  = 6'b000000; // {pcHold,stall_FD,stall_DX,stall_XM,flush_FD,flush_DX}
  localparam logic [5:0] O_LU    = 6'b110001;
  localparam logic [5:0] O_FLUSH = 6'b000011;
  localparam logic [5:0] O_FULL  = 6'b111100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  regSelRs_D, regSelRt_D, writeRegSel_X;
  logic        rsUsed_D, rtUsed_D, memRead_X, writeEn_X;
  logic        redirect_X, memReq_M, memDone_M, halt_M;
  logic        stall_FD, stall_DX, stall_XM, flush_FD, flush_DX, pcHold;
  logic [1:0]  state;
  logic        memFault;
  logic [15:0] stallCount;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$]; // {memFault, state, outs}

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .regSelRs_D(regSelRs_D), .regSelRt_D(regSelRt_D),
    .rsUsed_D(rsUsed_D), .rtUsed_D(rtUsed_D),
    .memRead_X(memRead_X), .writeEn_X(writeEn_X), .writeRegSel_X(writeRegSel_X),
    .redirect_X(redirect_X), .memReq_M(memReq_M), .memDone_M(memDone_M), .halt_M(halt_M),
    .stall_FD(stall_FD), .stall_DX(stall_DX), .stall_XM(stall_XM),
    .flush_FD(flush_FD), .flush_DX(flush_DX), .pcHold(pcHold),
    .state(state), .memFault(memFault), .stallCount(stallCount)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [5:0] outs_now();
    return {pcHold, stall_FD, stall_DX, stall_XM, flush_FD, flush_DX};
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    regSelRs_D = 3'd0; regSelRt_D = 3'd0; writeRegSel_X = 3'd0;
    rsUsed_D = 1'b0; rtUsed_D = 1'b0; memRead_X = 1'b0; writeEn_X = 1'b0;
    redirect_X = 1'b0; memReq_M = 1'b0; memDone_M = 1'b0; halt_M = 1'b0;
  endtask

  task automatic drive_load(input logic [2:0] dst, input logic [2:0] rs, input logic rsu,
                            input logic [2:0] rt, input logic rtu);
    memRead_X = 1'b1; writeEn_X = 1'b1; writeRegSel_X = dst;
    regSelRs_D = rs; rsUsed_D = rsu; regSelRt_D = rt; rtUsed_D = rtu;
  endtask

  task automatic apply_reset();
    next_cycle();
    drive_idle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  // scoreboard: pop one expected {memFault,state,outs} per cycle
  task automatic sb_check(input string name);
    logic [8:0] e;
    logic [8:0] a;
    @(negedge clk);
    a = {memFault, state, outs_now()};
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty got=%b", name, a);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s got {fault,state,outs}=%b expected=%b", name, a, e);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs_now() !== O_FLUSH) begin failures++; $display("FAIL rst_outs got=%b expected=%b", outs_now(), O_FLUSH); end
    checks++;
    if ({memFault, state, stallCount} !== 19'd0) begin
      failures++; $display("FAIL rst_state got fault=%b state=%0d cnt=%0d expected 0/0/0", memFault, state, stallCount);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_now() !== O_IDLE) begin failures++; $display("FAIL rst_release got=%b expected=%b", outs_now(), O_IDLE); end
  endtask

  task automatic test_load_use();
    next_cycle();
    drive_load(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs_now() !== O_LU) begin failures++; $display("FAIL lu_rs got=%b expected=%b", outs_now(), O_LU); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (outs_now() !== O_IDLE || stallCount !== 16'd1) begin
      failures++; $display("FAIL lu_rs_after got=%b cnt=%0d expected=%b cnt=1", outs_now(), stallCount, O_IDLE);
    end
    next_cycle();
    drive_load(3'd5, 3'd1, 1'b1, 3'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (outs_now() !== O_LU) begin failures++; $display("FAIL lu_rt got=%b expected=%b", outs_now(), O_LU); end
    next_cycle();
    drive_load(3'd5, 3'd5, 1'b1, 3'd5, 1'b1);
    writeEn_X = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_now() !== O_IDLE || stallCount !== 16'd2) begin
      failures++; $display("FAIL lu_nowrite got=%b cnt=%0d expected=%b cnt=2", outs_now(), stallCount, O_IDLE);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_load_use_unused();
    next_cycle();
    drive_load(3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs_now() !== O_IDLE) begin failures++; $display("FAIL lu_unused got=%b expected=%b", outs_now(), O_IDLE); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (stallCount !== 16'd2) begin failures++; $display("FAIL lu_unused_cnt got=%0d expected=2", stallCount); end
  endtask

  task automatic test_priority();
    next_cycle();
    drive_load(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    redirect_X = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_now() !== O_FLUSH) begin failures++; $display("FAIL redir_over_lu got=%b expected=%b", outs_now(), O_FLUSH); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (stallCount !== 16'd2 || state !== 2'd0) begin
      failures++; $display("FAIL redir_over_lu_cnt got cnt=%0d state=%0d expected cnt=2 state=0", stallCount, state);
    end
  endtask

  task automatic test_mem_redirect();
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 2'd1, O_FULL});
    exp_q.push_back({1'b0, 2'd2, O_FLUSH});
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      drive_idle();
      memReq_M   = (c == 0);
      redirect_X = (c == 2);
      memDone_M  = (c == 4);
      sb_check("mem_redirect");
    end
    checks++;
    if (stallCount !== 16'd6) begin failures++; $display("FAIL mem_redirect_cnt got=%0d expected=6", stallCount); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive_idle();
    memReq_M = 1'b1; memDone_M = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_now() !== O_IDLE) begin failures++; $display("FAIL req_done_same got=%b expected=%b", outs_now(), O_IDLE); end
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    exp_q.push_back({1'b0, 2'd1, O_FULL});
    exp_q.push_back({1'b0, 2'd0, O_LU});
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive_idle();
      memReq_M  = (c == 1);
      memDone_M = (c == 2);
      if (c == 3) drive_load(3'd2, 3'd0, 1'b0, 3'd2, 1'b1);
      sb_check("back_to_back");
    end
    checks++;
    if (stallCount !== 16'd8) begin failures++; $display("FAIL back_to_back_cnt got=%0d expected=8", stallCount); end
  endtask

  task automatic test_timeout();
    exp_q.push_back({1'b0, 2'd0, O_IDLE});
    for (int i = 1; i <= 8; i++) exp_q.push_back({1'b0, 2'd1, O_FULL});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 2'd3, O_FULL});
    for (int c = 0; c < 13; c++) begin
      next_cycle();
      drive_idle();
      memReq_M = (c == 0);
      if (c == 10) begin memDone_M = 1'b1; redirect_X = 1'b1; end
      sb_check("timeout");
    end
    checks++;
    if (stallCount !== 16'd19) begin failures++; $display("FAIL timeout_cnt got=%0d expected=19", stallCount); end
    apply_reset();
    @(negedge clk);
    checks++;
    if ({memFault, state, stallCount} !== 19'd0) begin
      failures++; $display("FAIL timeout_reset got fault=%b state=%0d cnt=%0d expected 0/0/0", memFault, state, stallCount);
    end
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    drive_idle();
    memReq_M = 1'b1;
    next_cycle();
    memReq_M = 1'b0;
    redirect_X = 1'b1;
    next_cycle();
    redirect_X = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_now() !== O_FLUSH || state !== 2'd1) begin
      failures++; $display("FAIL reset_mid_wait_outs got=%b state=%0d expected=%b state=1", outs_now(), state, O_FLUSH);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || stallCount !== 16'd0 || outs_now() !== O_IDLE) begin
      failures++; $display("FAIL reset_mid_wait_after got state=%0d cnt=%0d outs=%b expected 0/0/%b", state, stallCount, outs_now(), O_IDLE);
    end
    next_cycle();
    memDone_M = 1'b1;
    @(negedge clk);
    next_cycle();
    memDone_M = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_clears_pending got state=%0d expected=0", state); end
  endtask

  task automatic test_halt();
    next_cycle();
    drive_idle();
    halt_M = 1'b1; memReq_M = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (state !== 2'd3 || memFault !== 1'b0 || outs_now() !== O_FULL) begin
      failures++; $display("FAIL halt_run got state=%0d fault=%b outs=%b expected 3/0/%b", state, memFault, outs_now(), O_FULL);
    end
    apply_reset();
    memReq_M = 1'b1;
    next_cycle();
    memReq_M = 1'b0;
    halt_M = 1'b1; memDone_M = 1'b1; redirect_X = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (state !== 2'd3 || memFault !== 1'b0) begin
      failures++; $display("FAIL halt_wait got state=%0d fault=%b expected 3/0", state, memFault);
    end
    apply_reset();
  endtask

  task automatic test_saturation();
    next_cycle();
    drive_idle();
    halt_M = 1'b1;
    next_cycle();
    halt_M = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stallCount !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h expected=ffff", stallCount); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stallCount !== 16'd0 || state !== 2'd0) begin
      failures++; $display("FAIL sat_reset got cnt=%0d state=%0d expected 0/0", stallCount, state);
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_load_use_unused();
    test_priority();
    test_mem_redirect();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_halt();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
